// File: rtl/clk_freq_meter_pkg.sv
// Shared types and default widths for the clock frequency meter.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    REPORT
  } state_t;

  localparam int DEF_WIN_W       = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control/result bundle of the clock frequency meter.
// err_clr/err_sticky exist only with CLK_FREQ_METER_STICKY_ERR_EN.
interface clk_freq_meter_if #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
);
  logic             mon_clk;
  logic             start;
  logic             cont;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] exp_min;
  logic [CNT_W-1:0] exp_max;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_cnt;
  logic             in_range;
  logic             err_low;
  logic             err_high;
  logic             sat;
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
  logic             err_clr;
  logic             err_sticky;
`endif

  modport master (
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
    output err_clr,
    input  err_sticky,
`endif
    output mon_clk, start, cont, win_len, exp_min, exp_max,
    input  busy, done, edge_cnt, in_range, err_low, err_high, sat
  );

  modport slave (
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
    input  err_clr,
    output err_sticky,
`endif
    input  mon_clk, start, cont, win_len, exp_min, exp_max,
    output busy, done, edge_cnt, in_range, err_low, err_high, sat
  );
endinterface

// File: rtl/clk_freq_meter_edge_sync.sv
// Synchronizes mon_clk into the clk_in domain and flags each rising edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic mon_clk,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], mon_clk};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts mon_clk rising edges over a window of clk_in cycles and range-checks the result.
// Optional sticky error flag: CLK_FREQ_METER_STICKY_ERR_EN.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int WIN_W       = DEF_WIN_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          clk_in,
  input  logic          rst,
  clk_freq_meter_if.slave bus
);

  state_t           state, state_nxt;
  logic             rise;
  logic             win_last;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] work_cnt, cnt_nxt;
  logic [CNT_W-1:0] min_q, max_q;
  logic             work_sat, sat_nxt;
  logic             done_q, in_range_q, err_low_q, err_high_q, sat_q;
  logic [CNT_W-1:0] edge_cnt_q;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .mon_clk (bus.mon_clk),
    .rise    (rise)
  );

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign win_last = (state == MEASURE) && (win_cnt == WIN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ARM;
      ARM:     state_nxt = MEASURE;
      MEASURE: if (win_last) state_nxt = REPORT;
      REPORT:  state_nxt = bus.cont ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count including the edge detected in the current cycle, so the last
  // MEASURE cycle is counted when results are captured on entry to REPORT.
  always_comb begin
    cnt_nxt = work_cnt;
    if (rise && (work_cnt != '1)) cnt_nxt = work_cnt + CNT_W'(1);
    sat_nxt = work_sat | (cnt_nxt == '1);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      win_cnt  <= '0;
      work_cnt <= '0;
      work_sat <= 1'b0;
      min_q    <= '0;
      max_q    <= '0;
    end else begin
      case (state)
        ARM: begin
          min_q    <= bus.exp_min;
          max_q    <= bus.exp_max;
          work_cnt <= '0;
          work_sat <= 1'b0;
          win_cnt  <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
        end
        MEASURE: begin
          work_cnt <= cnt_nxt;
          work_sat <= sat_nxt;
          win_cnt  <= win_cnt - WIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      err_low_q  <= 1'b0;
      err_high_q <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      done_q <= win_last;
      if (win_last) begin
        edge_cnt_q <= cnt_nxt;
        sat_q      <= sat_nxt;
        err_low_q  <= cnt_nxt < min_q;
        err_high_q <= (cnt_nxt > max_q) || sat_nxt;
        in_range_q <= (cnt_nxt >= min_q) && (cnt_nxt <= max_q) && !sat_nxt;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.edge_cnt = edge_cnt_q;
  assign bus.sat      = sat_q;
  assign bus.err_low  = err_low_q;
  assign bus.err_high = err_high_q;
  assign bus.in_range = in_range_q;

`ifdef CLK_FREQ_METER_STICKY_ERR_EN
  logic err_sticky_q;

  // done marks the REPORT cycle in which the fresh flags are visible; set beats clear.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst)                                  err_sticky_q <= 1'b0;
    else if (done_q && (err_low_q || err_high_q)) err_sticky_q <= 1'b1;
    else if (bus.err_clr)                      err_sticky_q <= 1'b0;
  end

  assign bus.err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized self-checking bench for clk_freq_meter against a pin-history edge model.
module tb_clk_freq_meter;

  localparam int SYNC = 2;
  localparam int NCYC = 20000;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;
  int   mode   = 0;   // 0: mon_clk low, 1: clk_in/2, 2: random (no two highs in a row)
  logic pin [0:NCYC-1];

  clk_freq_meter_if #(.WIN_W(8), .CNT_W(8)) bus ();
  clk_freq_meter_if #(.WIN_W(8), .CNT_W(4)) b4 ();

  clk_freq_meter #(.WIN_W(8), .CNT_W(8), .SYNC_STAGES(SYNC)) u_dut (
    .clk_in (clk_in), .rst (rst), .bus (bus)
  );
  clk_freq_meter #(.WIN_W(8), .CNT_W(4), .SYNC_STAGES(SYNC)) u_dut4 (
    .clk_in (clk_in), .rst (rst), .bus (b4)
  );

  assign b4.mon_clk = bus.mon_clk;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    logic v;
    #1;
    v = bus.mon_clk;
    case (mode)
      1:       v = ~v;
      2:       v = v ? 1'b0 : 1'($urandom_range(0, 1));
      default: v = 1'b0;
    endcase
    bus.mon_clk = v;
    if (cyc < NCYC) pin[cyc] = v;
  end

  // Rising edge on the pin in cycle k is counted at clk edge k+SYNC+1;
  // a window started in cycle s owns the counting edges s+3 .. s+2+w.
  function automatic int model_count(input int s, input int w);
    int n = 0;
    for (int k = s + 2 - SYNC; k <= s + 1 + w - SYNC; k++)
      if (pin[k] && !pin[k-1]) n++;
    return n;
  endfunction

  task automatic pulse_start(input bit which, output int s);
    @(posedge clk_in); #1;
    if (which) b4.start = 1'b1; else bus.start = 1'b1;
    s = cyc;
    @(posedge clk_in); #1;
    b4.start  = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int limit, output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk_in);
      if ((which ? b4.done : bus.done) === 1'b1) begin ok = 1'b1; c = cyc; end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wait_cycles(3);
    tests++;
    if ({bus.busy, bus.done, bus.edge_cnt, bus.in_range, bus.err_low, bus.err_high, bus.sat} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d in=%b lo=%b hi=%b sat=%b, all must be 0",
               bus.busy, bus.done, bus.edge_cnt, bus.in_range, bus.err_low, bus.err_high, bus.sat);
    end
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
    tests++;
    if (bus.err_sticky !== 1'b0) begin
      failed++; $display("FAIL reset_sticky: got %b want 0", bus.err_sticky);
    end
`endif
    @(posedge clk_in); #1 rst = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_basic;
    int s, c, e; bit ok;
    mode = 1;
    wait_cycles(4);
    bus.win_len = 8'd20; bus.exp_min = 8'd9; bus.exp_max = 8'd11;
    pulse_start(1'b0, s);
    @(negedge clk_in);
    tests++;
    if (bus.busy !== 1'b1) begin failed++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    wait_done(1'b0, 60, c, ok);
    e = model_count(s, 20);
    tests++;
    if (!ok || c != s + 22) begin failed++; $display("FAIL basic_done_time: got %0d want %0d", c, s + 22); end
    tests++;
    if (bus.edge_cnt !== 8'(e) || e != 10) begin
      failed++; $display("FAIL basic_count: got %0d want %0d (model) / 10", bus.edge_cnt, e);
    end
    tests++;
    if ({bus.in_range, bus.err_low, bus.err_high, bus.sat} !== 4'b1000) begin
      failed++; $display("FAIL basic_flags: got in/lo/hi/sat=%b want 1000",
                         {bus.in_range, bus.err_low, bus.err_high, bus.sat});
    end
    wait_cycles(2);
  endtask

  task automatic test_idle_low;
    int s, c; bit ok;
    mode = 0;
    wait_cycles(4);
    bus.win_len = 8'd16; bus.exp_min = 8'd1; bus.exp_max = 8'd5;
    pulse_start(1'b0, s);
    wait_done(1'b0, 60, c, ok);
    tests++;
    if (!ok || bus.edge_cnt !== 8'd0 || {bus.in_range, bus.err_low, bus.err_high} !== 3'b010) begin
      failed++; $display("FAIL idle_low: ok=%b cnt=%0d in/lo/hi=%b want cnt 0 flags 010",
                         ok, bus.edge_cnt, {bus.in_range, bus.err_low, bus.err_high});
    end
    wait_cycles(2);
  endtask

  task automatic test_sat;
    int s, c, raw; bit ok;
    mode = 1;
    wait_cycles(3);
    b4.win_len = 8'd100; b4.exp_min = 4'd2; b4.exp_max = 4'd14;
    pulse_start(1'b1, s);
    wait_done(1'b1, 200, c, ok);
    raw = model_count(s, 100);
    tests++;
    if (!ok || c != s + 102) begin failed++; $display("FAIL sat_done_time: got %0d want %0d", c, s + 102); end
    tests++;
    if (b4.edge_cnt !== 4'd15 || raw < 15) begin
      failed++; $display("FAIL sat_count: got %0d want 15 (raw %0d)", b4.edge_cnt, raw);
    end
    tests++;
    if ({b4.sat, b4.err_high, b4.in_range, b4.err_low} !== 4'b1100) begin
      failed++; $display("FAIL sat_flags: got sat/hi/in/lo=%b want 1100",
                         {b4.sat, b4.err_high, b4.in_range, b4.err_low});
    end
    wait_cycles(2);
  endtask

  task automatic test_random;
    int s, c, w, weff, mn, mx, e; bit ok, lo, hi, inr;
    mode = 2;
    for (int it = 0; it < 10; it++) begin
      wait_cycles(3);
      w  = (it == 0) ? 0 : int'($urandom_range(1, 60));
      weff = (w == 0) ? 1 : w;
      mn = int'($urandom_range(0, 20));
      mx = (it % 4 == 3) ? mn - 1 : int'($urandom_range(0, 25));
      if (mx < 0) mx = 0;
      bus.win_len = 8'(w); bus.exp_min = 8'(mn); bus.exp_max = 8'(mx);
      pulse_start(1'b0, s);
      wait_done(1'b0, 100, c, ok);
      e   = model_count(s, weff);
      lo  = e < mn;
      hi  = e > mx;
      inr = !lo && !hi;
      tests++;
      if (!ok || c != s + 2 + weff) begin
        failed++; $display("FAIL rand_done_time[%0d]: got %0d want %0d", it, c, s + 2 + weff);
      end
      tests++;
      if (bus.edge_cnt !== 8'(e)) begin
        failed++; $display("FAIL rand_count[%0d]: got %0d want %0d (win %0d)", it, bus.edge_cnt, e, weff);
      end
      tests++;
      if ({bus.in_range, bus.err_low, bus.err_high, bus.sat} !== {inr, lo, hi, 1'b0}) begin
        failed++; $display("FAIL rand_flags[%0d]: got in/lo/hi/sat=%b want %b (cnt %0d min %0d max %0d)",
                           it, {bus.in_range, bus.err_low, bus.err_high, bus.sat},
                           {inr, lo, hi, 1'b0}, e, mn, mx);
      end
    end
    wait_cycles(2);
  endtask

  task automatic test_cont;
    int s, d1, d2, d3, extra; bit ok1, ok2, ok3;
    mode = 1;
    wait_cycles(3);
    bus.win_len = 8'd10; bus.exp_min = 8'd5; bus.exp_max = 8'd5; bus.cont = 1'b1;
    pulse_start(1'b0, s);
    wait_done(1'b0, 40, d1, ok1);
    @(negedge clk_in);
    tests++;
    if (bus.busy !== 1'b1) begin failed++; $display("FAIL cont_rearm_busy: got %b want 1", bus.busy); end
    wait_done(1'b0, 40, d2, ok2);
    wait_cycles(3);
    bus.cont = 1'b0;
    wait_done(1'b0, 40, d3, ok3);
    tests++;
    if (!ok1 || !ok2 || !ok3 || d1 != s + 12 || d2 - d1 != 12 || d3 - d2 != 12) begin
      failed++; $display("FAIL cont_spacing: done at %0d,%0d,%0d want %0d,%0d,%0d",
                         d1, d2, d3, s + 12, s + 24, s + 36);
    end
    tests++;
    if (bus.edge_cnt !== 8'(model_count(d2 - 2 + 2, 10)) || bus.in_range !== 1'b1) begin
      failed++; $display("FAIL cont_count: got %0d in=%b want %0d in=1",
                         bus.edge_cnt, bus.in_range, model_count(d2, 10));
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
    end
    tests++;
    if (extra != 0) begin failed++; $display("FAIL cont_stop: %0d busy/done cycles after last window, want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int s, s2, c, e, late; bit ok;
    mode = 1;
    bus.win_len = 8'd50; bus.exp_min = 8'd0; bus.exp_max = 8'd255;
    pulse_start(1'b0, s);
    wait_cycles(10);
    @(posedge clk_in); #3 rst = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.edge_cnt, bus.in_range, bus.err_low, bus.err_high, bus.sat} !== '0) begin
      failed++; $display("FAIL reset_mid: busy=%b cnt=%0d in=%b lo=%b hi=%b sat=%b, all must be 0",
                         bus.busy, bus.edge_cnt, bus.in_range, bus.err_low, bus.err_high, bus.sat);
    end
    @(posedge clk_in); #1 rst = 1'b1;
    wait_cycles(5);
    bus.win_len = 8'd20; bus.exp_min = 8'd9; bus.exp_max = 8'd11;
    pulse_start(1'b0, s);
    wait_cycles(3);
    pulse_start(1'b0, s2);
    wait_done(1'b0, 60, c, ok);
    e = model_count(s, 20);
    tests++;
    if (!ok || c != s + 22 || bus.edge_cnt !== 8'(e) || bus.in_range !== 1'b1) begin
      failed++; $display("FAIL reset_restart: done %0d cnt %0d in=%b want done %0d cnt %0d in=1 (2nd start %0d)",
                         c, bus.edge_cnt, bus.in_range, s + 22, e, s2);
    end
    late = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) late++;
    end
    tests++;
    if (late != 0) begin failed++; $display("FAIL busy_start_ignored: %0d active cycles after done, want 0", late); end
  endtask

`ifdef CLK_FREQ_METER_STICKY_ERR_EN
  task automatic test_sticky;
    int s, c; bit ok;
    mode = 1;
    wait_cycles(2);
    bus.exp_min = 8'd9; bus.exp_max = 8'd11;
    bus.win_len = 8'd10;
    pulse_start(1'b0, s);
    wait_done(1'b0, 40, c, ok);
    @(negedge clk_in);
    tests++;
    if (!ok || bus.err_sticky !== 1'b1) begin failed++; $display("FAIL sticky_set: got %b want 1", bus.err_sticky); end
    bus.win_len = 8'd20;
    pulse_start(1'b0, s);
    wait_done(1'b0, 40, c, ok);
    @(negedge clk_in);
    tests++;
    if (!ok || bus.in_range !== 1'b1 || bus.err_sticky !== 1'b1) begin
      failed++; $display("FAIL sticky_hold: in=%b sticky=%b want 1/1", bus.in_range, bus.err_sticky);
    end
    @(posedge clk_in); #1 bus.err_clr = 1'b1;
    @(posedge clk_in); #1 bus.err_clr = 1'b0;
    @(negedge clk_in);
    tests++;
    if (bus.err_sticky !== 1'b0) begin failed++; $display("FAIL sticky_clear: got %b want 0", bus.err_sticky); end
    bus.win_len = 8'd10;
    pulse_start(1'b0, s);
    while (cyc != s + 1 + 10) @(negedge clk_in);
    @(posedge clk_in); #1 bus.err_clr = 1'b1;
    @(posedge clk_in); #1 bus.err_clr = 1'b0;
    @(negedge clk_in);
    tests++;
    if (bus.err_sticky !== 1'b1) begin failed++; $display("FAIL sticky_set_wins: got %b want 1", bus.err_sticky); end
  endtask
`endif

  initial begin
    bus.mon_clk = 1'b0; bus.start = 1'b0; bus.cont = 1'b0;
    bus.win_len = '0; bus.exp_min = '0; bus.exp_max = '0;
    b4.start = 1'b0; b4.cont = 1'b0; b4.win_len = '0; b4.exp_min = '0; b4.exp_max = '0;
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
    bus.err_clr = 1'b0; b4.err_clr = 1'b0;
`endif
    for (int i = 0; i < NCYC; i++) pin[i] = 1'b0;
    test_reset();
    test_basic();
    test_idle_low();
    test_sat();
    test_random();
    test_cont();
    test_reset_mid();
`ifdef CLK_FREQ_METER_STICKY_ERR_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Measures the frequency of a monitored clock (typically the clk_in/2 output of the divide-by-2 stage) by counting its rising edges over a programmable window of clk_in cycles. Reports the edge count and compares it against a programmed [min, max] range. Sits directly downstream of the clock divider as its built-in checker. Usable in single-shot or continuous mode.

## Interface
- WIN_W, 8: width of the window length, in clk_in cycles
- CNT_W, 8: width of the edge counter
- SYNC_STAGES, 2: synchronizer depth on mon_clk (minimum 2)
- clk_in  input  1  sole clock; all logic on posedge
- rst  input  1  asynchronous, active-low reset
- mon_clk  input  1  monitored clock, sampled as data; must be at most clk_in/2
- start  input  1  one-cycle pulse; starts a measurement when idle
- cont  input  1  continuous mode; sampled when each window ends
- win_len  input  WIN_W  window length in cycles; latched in ARM; 0 is treated as 1
- exp_min  input  CNT_W  lower bound of the range; latched in ARM
- exp_max  input  CNT_W  upper bound of the range; latched in ARM
- busy  output  1  high from ARM through REPORT
- done  output  1  one-cycle pulse when the result outputs update
- edge_cnt  output  CNT_W  last completed count
- in_range  output  1  exp_min ≤ edge_cnt ≤ exp_max, and no saturation
- err_low  output  1  edge_cnt < exp_min
- err_high  output  1  edge_cnt > exp_max, or saturated
- sat  output  1  counter reached all-ones during the window
- err_clr  input  1  clears err_sticky; present only with the macro
- err_sticky  output  1  present only with the macro

## Operation
- Edge detection runs continuously from reset.
  - mon_clk passes through SYNC_STAGES flops, then one history flop.
  - Rising edge = synchronized value high and history flop low.
- FSM states: IDLE, ARM, MEASURE, REPORT.
  - IDLE → ARM on start.
  - ARM (1 cycle): latch win_len, exp_min and exp_max; clear the working counter and sat; load the window counter → MEASURE.
  - MEASURE: lasts exactly max(win_len, 1) cycles. Every detected edge in these cycles increments the working counter, which saturates at all-ones and sets sat → REPORT.
  - REPORT (1 cycle): register edge_cnt, the flags and sat; pulse done. Then go to ARM if cont = 1, otherwise IDLE.
- start is ignored while busy. Dropping cont mid-window finishes that window, then returns to IDLE.
- Comparison uses the latched bounds. If exp_min > exp_max, in_range is never set; err_low and err_high follow their definitions independently.
- Reset mid-operation: FSM returns to IDLE immediately; all outputs clear.

## Timing
- Every output resets to 0.
- Results hold their values until the next REPORT.
- Latency from a mon_clk rising edge to detection is SYNC_STAGES+1 cycles. Edges are attributed to the window by detection time, not by pin time.
- From start, busy rises on the next cycle.
- done occurs max(win_len,1)+2 cycles after the start cycle: ARM + MEASURE + REPORT.
- Continuous mode has a 2-cycle gap (REPORT + ARM) between windows. Edges detected in those cycles are not counted.

## Configuration
- CLK_FREQ_METER_STICKY_ERR_EN
  - Defined: adds err_clr and err_sticky. err_sticky sets on any REPORT with err_low or err_high and holds until err_clr or reset. If err_clr and a setting REPORT occur in the same cycle, the set wins.
  - Undefined: neither port exists and no flag logic is built.

## Structure
- clk_freq_meter_pkg: FSM state enum (IDLE, ARM, MEASURE, REPORT) and the default width constants.
- Sub-module edge_sync: synchronizer plus rising-edge detector, parameterized by SYNC_STAGES, with the same clock and reset. The FSM, counters and comparators stay in the top module.

## Test plan
- mon_clk = clk_in/2; win_len=20, exp_min=9, exp_max=11; pulse start → done at start+22 cycles; edge_cnt=10, in_range=1.
- mon_clk held at 0; win_len=16, exp_min=1 → edge_cnt=0, err_low=1, in_range=0.
- CNT_W=4, mon_clk = clk_in/2, win_len=100 → edge_cnt=15, sat=1, err_high=1.
- cont=1 for 3 windows with win_len=10 → done pulses 12 cycles apart; cont dropped during window 3 → FSM returns to IDLE after that window's done.
- rst asserted mid-MEASURE → all outputs 0 asynchronously. After release, a new start measures correctly; a start pulsed while busy is ignored.
- Macro defined: out-of-range window → err_sticky=1 and held through a following in-range window; err_clr → 0; err_clr coincident with an error REPORT → stays 1.
